sme_stream_tx: RTL and testbench
================================

// Module: sme_stream_tx
// PURPOSE
//  Host-side transmitter for the string-matching engine's byte-stream interface. Holds one string
//  (up to 32 chars) and one pattern (up to 8 chars) written by the host, then streams them out.
//  Streaming uses chardata with the isstring/ispattern strobes, one char per cycle.
//  It then waits for the engine's valid pulse, captures match/match_index and reports completion.
//  It sits between the test/host controller and the engine, driving exactly the stream the engine receives.
// PARAMETERS
//  STR_MAX  32   max string length in chars (buffer depth)
//  PAT_MAX  8    max pattern length in chars (buffer depth)
//  TIMEOUT  255  cycles to wait for valid after the last pattern char before giving up (>=1)
// PORTS
//  clk          in   1  single clock, all logic on rising edge
//  reset        in   1  synchronous, active-high reset
//  wr_en        in   1  host buffer write strobe (ignored while busy=1)
//  wr_sel       in   1  0 = string buffer, 1 = pattern buffer
//  wr_addr      in   5  char index (pattern uses [2:0]; string addr>=STR_MAX or pattern addr>=PAT_MAX dropped)
//  wr_data      in   8  character byte
//  str_len      in   6  string length, legal 1..STR_MAX, sampled at start
//  pat_len      in   4  pattern length, legal 1..PAT_MAX, sampled at start
//  start        in   1  launch one transaction (accepted only in IDLE)
//  reuse_string in   1  1 = skip string phase, send pattern only (engine keeps previous string)
//  chardata     out  8  char to engine; 8'h00 when no strobe is high
//  isstring     out  1  chardata is a string char
//  ispattern    out  1  chardata is a pattern char
//  valid        in   1  engine result strobe
//  match        in   1  engine match flag, sampled with valid
//  match_index  in   5  engine match position, sampled with valid
//  busy         out  1  high from the cycle after start accepted until done pulse
//  done         out  1  one-cycle pulse: result registers updated
//  res_match    out  1  captured match (0 on timeout)
//  res_index    out  5  captured match_index (0 on timeout)
//  timeout      out  1  set with done if no valid arrived; held until next accepted start
//  err          out  1  one-cycle pulse: start rejected
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; str_sent flag cleared. Buffer contents retained, not cleared.
//  FSM: IDLE -> SEND_S -> SEND_P -> WAIT -> IDLE; the done pulse is issued on the WAIT->IDLE transition.
//  IDLE: start=1 checked on the same edge:
//   - Rejected (err=1 next cycle, state stays IDLE, no strobes) if any of:
//     pat_len==0 or pat_len>PAT_MAX; or
//     reuse_string=0 and (str_len==0 or str_len>STR_MAX); or
//     reuse_string=1 and str_sent==0.
//   - Otherwise lengths are latched, and the next state is SEND_S (reuse_string=0) or SEND_P (reuse_string=1).
//  SEND_S: isstring=1, chardata=string[i], i=0..len-1, one per cycle, back-to-back.
//   - After the last char the next cycle is SEND_P with no gap; the engine requires the pattern to follow isstring immediately.
//   - str_sent is set on leaving SEND_S.
//  SEND_P: ispattern=1, chardata=pattern[j], j=0..len-1, back-to-back. Then WAIT: both strobes 0, chardata=0.
//  Timing: if start is accepted at edge T, the first char is on the outputs in cycle T+1.
//   - Full send occupies str_len+pat_len cycles, or pat_len with reuse_string.
//  WAIT: cycle counter from 0.
//   - valid=1 -> capture match/match_index into res_*, done=1 the next cycle, go to IDLE.
//   - Counter reaches TIMEOUT with no valid -> done=1, timeout=1, res_match=0, res_index=0, go to IDLE.
//   - valid and timeout on the same cycle: valid wins.
//  valid seen outside WAIT: ignored, not stored.
//  Writes while busy=1: ignored. A write in the same cycle as an accepted start: ignored.
//  start while busy: ignored, no err.
//  Reset mid-operation: strobes drop to 0 on the next cycle; no done is issued; str_sent=0.
//  Outputs chardata/isstring/ispattern/done/err/res_* are registered (no combinational input->output paths).
// TESTING
//  1. Load string "abcd" (61..64), pattern "bc", str_len=4, pat_len=2, start at T
//     -> isstring chars 61,62,63,64 at T+1..T+4; ispattern 62,63 at T+5..T+6.
//     Model valid/match=1/idx=1 at T+9 -> done=1 at T+10, res_match=1, res_index=1.
//  2. After #1, pattern "d", pat_len=1, reuse_string=1, start -> no isstring; one ispattern cycle with 0x64.
//     Result captured -> done pulse, busy low afterwards.
//  3. TIMEOUT=16, engine never asserts valid -> done+timeout=1 exactly 16 cycles after entering WAIT.
//     res_match=0; the next accepted start clears timeout.
//  4. pat_len=0 start -> err pulse, busy stays 0, no strobes.
//     After reset, reuse_string=1 start -> err pulse.
//  5. Assert reset during SEND_S at the 3rd char -> next cycle isstring=0, busy=0, no done; reuse_string start then -> err.
//  6. str_len=32 with chars 0x00..0x1F, pat_len=8 -> 32 string + 8 pattern cycles back-to-back.
//     wr_en pulses while busy do not alter buffers; verified on a re-send.

Source files
------------

// File: rtl/sme_stream_tx_if.sv
// Host/engine bus for sme_stream_tx: buffer writes, transaction control,
// the character stream toward the engine and the captured result.
interface sme_stream_tx_if;
  logic       wr_en;
  logic       wr_sel;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       start;
  logic       reuse_string;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;
  logic       busy;
  logic       done;
  logic       res_match;
  logic [4:0] res_index;
  logic       timeout;
  logic       err;

  // The transmitter itself
  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, start, reuse_string,
    input  valid, match, match_index,
    output chardata, isstring, ispattern, busy, done, res_match, res_index, timeout, err
  );

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, str_len, pat_len, start, reuse_string,
    output valid, match, match_index,
    input  chardata, isstring, ispattern, busy, done, res_match, res_index, timeout, err
  );
endinterface

// File: rtl/sme_stream_tx.sv
// Host-side transmitter for the string-matching engine: buffers one string and
// one pattern, streams them one char per cycle, then captures the engine result.
module sme_stream_tx #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  sme_stream_tx_if.slave  bus
);

  localparam int SA_W  = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
  localparam int PA_W  = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [5:0]       STR_MAX_L = 6'(STR_MAX);
  localparam logic [5:0]       PAT_MAX_L = 6'(PAT_MAX);

  typedef enum logic [1:0] {IDLE, SEND_S, SEND_P, WAIT} state_t;

  logic [7:0] str_buf_q [STR_MAX];
  logic [7:0] pat_buf_q [PAT_MAX];

  state_t           state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [5:0]       str_len_q, str_len_d;
  logic [3:0]       pat_len_q, pat_len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             str_sent_q, str_sent_d;
  logic [7:0]       chardata_q, chardata_d;
  logic             isstring_q, isstring_d;
  logic             ispattern_q, ispattern_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             res_match_q, res_match_d;
  logic [4:0]       res_index_q, res_index_d;
  logic             timeout_q, timeout_d;
  logic             err_q, err_d;
  logic             start_bad, start_ok, str_we, pat_we;

  always_comb begin
    start_bad = (bus.pat_len == 4'd0) || ({2'b00, bus.pat_len} > PAT_MAX_L) ||
                (!bus.reuse_string && ((bus.str_len == 6'd0) || (bus.str_len > STR_MAX_L))) ||
                (bus.reuse_string && !str_sent_q);
    start_ok  = (state_q == IDLE) && bus.start && !start_bad;

    state_d     = state_q;
    idx_d       = idx_q;
    str_len_d   = str_len_q;
    pat_len_d   = pat_len_q;
    cnt_d       = cnt_q;
    str_sent_d  = str_sent_q;
    chardata_d  = chardata_q;
    isstring_d  = isstring_q;
    ispattern_d = ispattern_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    res_match_d = res_match_q;
    res_index_d = res_index_q;
    timeout_d   = timeout_q;
    str_we      = 1'b0;
    pat_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wr_en && !start_ok) begin
          str_we = !bus.wr_sel && ({1'b0, bus.wr_addr} < STR_MAX_L);
          pat_we =  bus.wr_sel && ({1'b0, bus.wr_addr} < PAT_MAX_L);
        end
        if (bus.start && start_bad) begin
          err_d = 1'b1;
        end else if (start_ok) begin
          // First char is loaded here so it appears in the cycle right after start
          str_len_d = bus.str_len;
          pat_len_d = bus.pat_len;
          busy_d    = 1'b1;
          timeout_d = 1'b0;
          idx_d     = 6'd1;
          if (bus.reuse_string) begin
            state_d     = SEND_P;
            ispattern_d = 1'b1;
            chardata_d  = pat_buf_q[0];
          end else begin
            state_d    = SEND_S;
            isstring_d = 1'b1;
            chardata_d = str_buf_q[0];
          end
        end
      end
      SEND_S: begin
        if (idx_q == str_len_q) begin
          state_d     = SEND_P;
          isstring_d  = 1'b0;
          ispattern_d = 1'b1;
          chardata_d  = pat_buf_q[0];
          idx_d       = 6'd1;
          str_sent_d  = 1'b1;
        end else begin
          chardata_d = str_buf_q[idx_q[SA_W-1:0]];
          idx_d      = idx_q + 6'd1;
        end
      end
      SEND_P: begin
        if (idx_q == {2'b00, pat_len_q}) begin
          state_d     = WAIT;
          ispattern_d = 1'b0;
          chardata_d  = 8'h00;
          cnt_d       = '0;
        end else begin
          chardata_d = pat_buf_q[idx_q[PA_W-1:0]];
          idx_d      = idx_q + 6'd1;
        end
      end
      WAIT: begin
        if (bus.valid) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          res_match_d = bus.match;
          res_index_d = bus.match_index;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          res_match_d = 1'b0;
          res_index_d = 5'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffers are deliberately left out of reset so the host can reuse them
  always_ff @(posedge clk) begin
    if (str_we) str_buf_q[bus.wr_addr[SA_W-1:0]] <= bus.wr_data;
    if (pat_we) pat_buf_q[bus.wr_addr[PA_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      str_len_q   <= '0;
      pat_len_q   <= '0;
      cnt_q       <= '0;
      str_sent_q  <= 1'b0;
      chardata_q  <= '0;
      isstring_q  <= 1'b0;
      ispattern_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_match_q <= 1'b0;
      res_index_q <= '0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      str_len_q   <= str_len_d;
      pat_len_q   <= pat_len_d;
      cnt_q       <= cnt_d;
      str_sent_q  <= str_sent_d;
      chardata_q  <= chardata_d;
      isstring_q  <= isstring_d;
      ispattern_q <= ispattern_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_match_q <= res_match_d;
      res_index_q <= res_index_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign bus.chardata  = chardata_q;
  assign bus.isstring  = isstring_q;
  assign bus.ispattern = ispattern_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.res_match = res_match_q;
  assign bus.res_index = res_index_q;
  assign bus.timeout   = timeout_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sme_stream_tx.sv
// Directed testbench for sme_stream_tx: streaming order/timing, reuse,
// timeout, start rejection, mid-operation reset and full-length sends.
module tb_sme_stream_tx;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  sme_stream_tx_if bus_if ();

  sme_stream_tx #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = sel;
    bus_if.wr_addr = addr;
    bus_if.wr_data = data;
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic launch(input logic [5:0] slen, input logic [3:0] plen, input logic reuse);
    bus_if.str_len      = slen;
    bus_if.pat_len      = plen;
    bus_if.reuse_string = reuse;
    bus_if.start        = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.chardata} !== 10'd0) begin
      $display("[TB] FAIL reset_stream: got %b/%b/%h expected 0/0/00",
               bus_if.isstring, bus_if.ispattern, bus_if.chardata);
      n_fail++;
    end
    n_cmp++;
    if ({bus_if.busy, bus_if.done, bus_if.err, bus_if.timeout} !== 4'b0000) begin
      $display("[TB] FAIL reset_status: got busy/done/err/timeout=%b expected 0000",
               {bus_if.busy, bus_if.done, bus_if.err, bus_if.timeout});
      n_fail++;
    end
    n_cmp++;
    if ({bus_if.res_match, bus_if.res_index} !== 6'd0) begin
      $display("[TB] FAIL reset_result: got %b/%0d expected 0/0", bus_if.res_match, bus_if.res_index);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_c;
    write_char(1'b0, 5'd0, 8'h61);
    write_char(1'b0, 5'd1, 8'h62);
    write_char(1'b0, 5'd2, 8'h63);
    write_char(1'b0, 5'd3, 8'h64);
    write_char(1'b1, 5'd0, 8'h62);
    write_char(1'b1, 5'd1, 8'h63);
    launch(6'd4, 4'd2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      exp_c = (k < 4) ? 8'(8'h61 + k) : 8'(8'h62 + k - 4);
      n_cmp++;
      if ({bus_if.isstring, bus_if.ispattern, bus_if.chardata, bus_if.busy} !==
          {(k < 4), (k >= 4), exp_c, 1'b1}) begin
        $display("[TB] FAIL basic_char[%0d]: got s/p/c/busy=%b/%b/%h/%b expected %b/%b/%h/1", k,
                 bus_if.isstring, bus_if.ispattern, bus_if.chardata, bus_if.busy, (k < 4), (k >= 4), exp_c);
        n_fail++;
      end
      tick();
    end
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.chardata, bus_if.busy} !== {10'd0, 1'b1}) begin
      $display("[TB] FAIL basic_wait: got s/p/c/busy=%b/%b/%h/%b expected 0/0/00/1",
               bus_if.isstring, bus_if.ispattern, bus_if.chardata, bus_if.busy);
      n_fail++;
    end
    tick();
    tick();
    bus_if.valid       = 1'b1;
    bus_if.match       = 1'b1;
    bus_if.match_index = 5'd1;
    tick();
    bus_if.valid = 1'b0;
    n_cmp++;
    if ({bus_if.done, bus_if.res_match, bus_if.res_index, bus_if.timeout} !== {2'b11, 5'd1, 1'b0}) begin
      $display("[TB] FAIL basic_done: got done/match/idx/to=%b/%b/%0d/%b expected 1/1/1/0",
               bus_if.done, bus_if.res_match, bus_if.res_index, bus_if.timeout);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({bus_if.done, bus_if.busy} !== 2'b00) begin
      $display("[TB] FAIL basic_after: got done/busy=%b/%b expected 0/0", bus_if.done, bus_if.busy);
      n_fail++;
    end
  endtask

  task automatic test_reuse();
    write_char(1'b1, 5'd0, 8'h64);
    launch(6'd0, 4'd1, 1'b1);
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.chardata} !== {2'b01, 8'h64}) begin
      $display("[TB] FAIL reuse_char: got s/p/c=%b/%b/%h expected 0/1/64",
               bus_if.isstring, bus_if.ispattern, bus_if.chardata);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.busy} !== 3'b001) begin
      $display("[TB] FAIL reuse_wait: got s/p/busy=%b/%b/%b expected 0/0/1",
               bus_if.isstring, bus_if.ispattern, bus_if.busy);
      n_fail++;
    end
    bus_if.valid       = 1'b1;
    bus_if.match       = 1'b1;
    bus_if.match_index = 5'd3;
    tick();
    bus_if.valid = 1'b0;
    n_cmp++;
    if ({bus_if.done, bus_if.res_match, bus_if.res_index} !== {2'b11, 5'd3}) begin
      $display("[TB] FAIL reuse_done: got done/match/idx=%b/%b/%0d expected 1/1/3",
               bus_if.done, bus_if.res_match, bus_if.res_index);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({bus_if.done, bus_if.busy} !== 2'b00) begin
      $display("[TB] FAIL reuse_after: got done/busy=%b/%b expected 0/0", bus_if.done, bus_if.busy);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    launch(6'd0, 4'd1, 1'b1);
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      n_cmp++;
      if (bus_if.done !== 1'b0) begin
        $display("[TB] FAIL timeout_early[%0d]: got done=%b expected 0", i, bus_if.done);
        n_fail++;
      end
    end
    tick();
    n_cmp++;
    if ({bus_if.done, bus_if.timeout, bus_if.res_match, bus_if.res_index} !== {2'b11, 6'd0}) begin
      $display("[TB] FAIL timeout_done: got done/to/match/idx=%b/%b/%b/%0d expected 1/1/0/0",
               bus_if.done, bus_if.timeout, bus_if.res_match, bus_if.res_index);
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({bus_if.done, bus_if.timeout, bus_if.busy} !== 3'b010) begin
      $display("[TB] FAIL timeout_hold: got done/to/busy=%b/%b/%b expected 0/1/0",
               bus_if.done, bus_if.timeout, bus_if.busy);
      n_fail++;
    end
    launch(6'd0, 4'd1, 1'b1);
    n_cmp++;
    if (bus_if.timeout !== 1'b0) begin
      $display("[TB] FAIL timeout_clear: got timeout=%b expected 0", bus_if.timeout);
      n_fail++;
    end
    tick();
    bus_if.valid       = 1'b1;
    bus_if.match       = 1'b0;
    bus_if.match_index = 5'd0;
    tick();
    bus_if.valid = 1'b0;
    tick();
  endtask

  task automatic test_reject();
    launch(6'd4, 4'd0, 1'b0);
    n_cmp++;
    if ({bus_if.err, bus_if.busy, bus_if.isstring, bus_if.ispattern} !== 4'b1000) begin
      $display("[TB] FAIL reject_patlen0: got err/busy/s/p=%b expected 1000",
               {bus_if.err, bus_if.busy, bus_if.isstring, bus_if.ispattern});
      n_fail++;
    end
    tick();
    n_cmp++;
    if ({bus_if.err, bus_if.busy} !== 2'b00) begin
      $display("[TB] FAIL reject_pulse: got err/busy=%b/%b expected 0/0", bus_if.err, bus_if.busy);
      n_fail++;
    end
    launch(6'd4, 4'd9, 1'b0);
    n_cmp++;
    if ({bus_if.err, bus_if.busy} !== 2'b10) begin
      $display("[TB] FAIL reject_patlen9: got err/busy=%b/%b expected 1/0", bus_if.err, bus_if.busy);
      n_fail++;
    end
    launch(6'd33, 4'd2, 1'b0);
    n_cmp++;
    if ({bus_if.err, bus_if.busy} !== 2'b10) begin
      $display("[TB] FAIL reject_strlen33: got err/busy=%b/%b expected 1/0", bus_if.err, bus_if.busy);
      n_fail++;
    end
    bus_if.valid       = 1'b1;
    bus_if.match       = 1'b1;
    bus_if.match_index = 5'd7;
    tick();
    bus_if.valid = 1'b0;
    tick();
    n_cmp++;
    if ({bus_if.done, bus_if.res_match, bus_if.res_index} !== 7'd0) begin
      $display("[TB] FAIL idle_valid: got done/match/idx=%b/%b/%0d expected 0/0/0",
               bus_if.done, bus_if.res_match, bus_if.res_index);
      n_fail++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch(6'd0, 4'd1, 1'b1);
    n_cmp++;
    if ({bus_if.err, bus_if.ispattern, bus_if.busy} !== 3'b100) begin
      $display("[TB] FAIL reject_reuse: got err/p/busy=%b/%b/%b expected 1/0/0",
               bus_if.err, bus_if.ispattern, bus_if.busy);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    launch(6'd4, 4'd2, 1'b0);
    tick();
    tick();
    n_cmp++;
    if ({bus_if.isstring, bus_if.chardata} !== {1'b1, 8'h63}) begin
      $display("[TB] FAIL midrst_third: got s/c=%b/%h expected 1/63", bus_if.isstring, bus_if.chardata);
      n_fail++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.busy, bus_if.done, bus_if.chardata} !== 12'd0) begin
      $display("[TB] FAIL midrst_drop: got s/p/busy/done=%b/%b/%b/%b c=%h expected 0/0/0/0 c=00",
               bus_if.isstring, bus_if.ispattern, bus_if.busy, bus_if.done, bus_if.chardata);
      n_fail++;
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus_if.done, bus_if.isstring, bus_if.ispattern} !== 3'b000) begin
        $display("[TB] FAIL midrst_quiet[%0d]: got done/s/p=%b/%b/%b expected 0/0/0",
                 i, bus_if.done, bus_if.isstring, bus_if.ispattern);
        n_fail++;
      end
    end
    launch(6'd0, 4'd1, 1'b1);
    n_cmp++;
    if ({bus_if.err, bus_if.ispattern} !== 2'b10) begin
      $display("[TB] FAIL midrst_reuse: got err/p=%b/%b expected 1/0", bus_if.err, bus_if.ispattern);
      n_fail++;
    end
    tick();
  endtask

  task automatic check_full_send(input string tag);
    logic [7:0] exp_c;
    for (int k = 0; k < 40; k++) begin
      exp_c = (k < 32) ? 8'(k) : 8'(8'hA0 + k - 32);
      if (k == 3) begin
        bus_if.wr_en = 1'b1; bus_if.wr_sel = 1'b0; bus_if.wr_addr = 5'd5; bus_if.wr_data = 8'hFF;
      end else if (k == 4) begin
        bus_if.wr_sel = 1'b1; bus_if.wr_addr = 5'd2; bus_if.wr_data = 8'hEE;
      end else if (k == 5) begin
        bus_if.wr_en = 1'b0;
      end
      n_cmp++;
      if ({bus_if.isstring, bus_if.ispattern, bus_if.chardata} !== {(k < 32), (k >= 32), exp_c}) begin
        $display("[TB] FAIL %s[%0d]: got s/p/c=%b/%b/%h expected %b/%b/%h", tag, k,
                 bus_if.isstring, bus_if.ispattern, bus_if.chardata, (k < 32), (k >= 32), exp_c);
        n_fail++;
      end
      tick();
    end
    n_cmp++;
    if ({bus_if.isstring, bus_if.ispattern, bus_if.busy} !== 3'b001) begin
      $display("[TB] FAIL %s_wait: got s/p/busy=%b/%b/%b expected 0/0/1", tag,
               bus_if.isstring, bus_if.ispattern, bus_if.busy);
      n_fail++;
    end
    bus_if.valid       = 1'b1;
    bus_if.match       = 1'b1;
    bus_if.match_index = 5'd20;
    tick();
    bus_if.valid = 1'b0;
    n_cmp++;
    if ({bus_if.done, bus_if.res_match, bus_if.res_index} !== {2'b11, 5'd20}) begin
      $display("[TB] FAIL %s_done: got done/match/idx=%b/%b/%0d expected 1/1/20", tag,
               bus_if.done, bus_if.res_match, bus_if.res_index);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) write_char(1'b0, 5'(i), 8'(i));
    for (int j = 0; j < 8; j++) write_char(1'b1, 5'(j), 8'(8'hA0 + j));
    launch(6'd32, 4'd8, 1'b0);
    check_full_send("full1");
    bus_if.wr_en   = 1'b1;
    bus_if.wr_sel  = 1'b0;
    bus_if.wr_addr = 5'd0;
    bus_if.wr_data = 8'h55;
    launch(6'd32, 4'd8, 1'b0);
    bus_if.wr_en = 1'b0;
    check_full_send("full2");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset                = 1'b0;
    bus_if.wr_en         = 1'b0;
    bus_if.wr_sel        = 1'b0;
    bus_if.wr_addr       = 5'd0;
    bus_if.wr_data       = 8'h00;
    bus_if.str_len       = 6'd0;
    bus_if.pat_len       = 4'd0;
    bus_if.start         = 1'b0;
    bus_if.reuse_string  = 1'b0;
    bus_if.valid         = 1'b0;
    bus_if.match         = 1'b0;
    bus_if.match_index   = 5'd0;
    test_reset();
    test_basic();
    test_reuse();
    test_timeout();
    test_reject();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
